// File: rtl/falafel_mem_ctrl.sv
// falafel_mem_ctrl: executes read/write/CAS requests against a 1-cycle-latency single-port SRAM.
// CAS is atomic by construction: the FSM accepts nothing new until the response has been taken.
module falafel_mem_ctrl #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       MEM_WORDS = 1024,
    parameter logic [DATA_W-1:0] BASE_ADDR = '0,
    localparam int unsigned      ADDR_W    = $clog2(MEM_WORDS),
    localparam int unsigned      OFS_W     = $clog2(DATA_W / 8)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    input  logic [DATA_W-1:0] mem_req_cas_exp_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic [15:0]       cas_fail_cnt_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RSP} state_e;

    state_e            state_q;
    logic              rd_q, cas_q, hit_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q, exp_q, rsp_q, off;
    logic [15:0]       cnt_q;
    logic              acc_en, cas_ok;

    assign off            = mem_req_addr_i - BASE_ADDR;
    assign acc_en         = state_q == ACCESS && hit_q;
    // The conditional CAS write has to follow rdata in the same cycle it arrives.
    assign cas_ok         = state_q == WAIT && cas_q && sram_rdata_i == exp_q;
    assign mem_req_rdy_o  = state_q == IDLE;
    assign mem_rsp_val_o  = state_q == RSP;
    assign mem_rsp_data_o = rsp_q;
    assign cas_fail_cnt_o = cnt_q;
    assign sram_en_o      = acc_en || cas_ok;
    assign sram_we_o      = (acc_en && !rd_q && !cas_q) || cas_ok;
    assign sram_addr_o    = sram_en_o ? idx_q : '0;
    assign sram_wdata_o   = sram_we_o ? data_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            cas_q   <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            exp_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (mem_req_val_i) begin
                    rd_q    <= !mem_req_is_write_i;
                    cas_q   <= mem_req_is_write_i && mem_req_is_cas_i;
                    hit_q   <= mem_req_addr_i >= BASE_ADDR && (off >> OFS_W) < DATA_W'(MEM_WORDS);
                    idx_q   <= off[OFS_W +: ADDR_W];
                    data_q  <= mem_req_data_i;
                    exp_q   <= mem_req_cas_exp_i;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    rsp_q   <= !hit_q ? '1 : data_q;
                    state_q <= (!hit_q || (!rd_q && !cas_q)) ? RSP : WAIT;
                end
                WAIT: begin
                    rsp_q   <= sram_rdata_i;
                    if (cas_q && sram_rdata_i != exp_q && cnt_q != 16'hFFFF)
                        cnt_q <= cnt_q + 16'd1;
                    state_q <= RSP;
                end
                RSP: if (mem_rsp_rdy_i) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_falafel_mem_ctrl.sv
// tb_falafel_mem_ctrl: directed bench with a behavioural SRAM and a response scoreboard.
module tb_falafel_mem_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_val = 1'b0, req_rdy, is_write = 1'b0, is_cas = 1'b0;
    logic [63:0] addr = '0, wdata = '0, cas_exp = '0;
    logic        rsp_val, rsp_rdy = 1'b1;
    logic [63:0] rsp_data;
    logic        sram_en, sram_we;
    logic [3:0]  sram_addr;
    logic [63:0] sram_wdata, sram_rdata = '0;
    logic [15:0] fail_cnt;
    logic [63:0] mem [16] = '{default: 64'h0};

    int checks = 0, errors = 0;
    int got, we_cnt, we_cyc, en_cnt;
    logic [3:0]  we_addr;
    logic [63:0] we_data;
    logic [63:0] sb [$];

    falafel_mem_ctrl #(.DATA_W(64), .MEM_WORDS(16), .BASE_ADDR(64'h1000)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_val_i(req_val), .mem_req_rdy_o(req_rdy),
        .mem_req_is_write_i(is_write), .mem_req_is_cas_i(is_cas),
        .mem_req_addr_i(addr), .mem_req_data_i(wdata), .mem_req_cas_exp_i(cas_exp),
        .mem_rsp_val_o(rsp_val), .mem_rsp_rdy_i(rsp_rdy), .mem_rsp_data_o(rsp_data),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .cas_fail_cnt_o(fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sram_en) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and watches SRAM activity until the response shows up (bounded).
    task automatic start(input logic w, input logic c, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] e, input logic [63:0] rsp_exp);
        check("req_rdy_idle", req_rdy, 1'b1);
        req_val = 1'b1; is_write = w; is_cas = c; addr = a; wdata = d; cas_exp = e;
        sb.push_back(rsp_exp);
        step();
        req_val = 1'b0; is_write = 1'b1; is_cas = 1'b1; addr = '1; wdata = '1; cas_exp = '1;
        got = 0; we_cnt = 0; we_cyc = 0; en_cnt = 0; we_addr = '0; we_data = '0;
        for (int k = 1; k <= 10 && got == 0; k++) begin
            if (sram_en) en_cnt++;
            if (sram_we) begin we_cnt++; we_cyc = k; we_addr = sram_addr; we_data = sram_wdata; end
            if (rsp_val) got = k;
            else step();
        end
        if (got == 0) check("rsp_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) check({tag, "_sb_empty"}, 1'b1, 1'b0);
        else begin
            e = sb.pop_front();
            check({tag, "_data"}, rsp_data, e);
        end
        step();
        check({tag, "_val_clr"}, rsp_val, 1'b0);
        check({tag, "_rdy_back"}, req_rdy, 1'b1);
    endtask

    initial begin
        #12;
        check("rst_req_rdy", req_rdy, 1'b1);
        check("rst_rsp_val", rsp_val, 1'b0);
        check("rst_sram_en", sram_en, 1'b0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_fail_cnt", fail_cnt, 16'h0);
        step();
        rst_n = 1'b1;
        step();

        // 1: write then read with ignored offset bits
        start(1'b1, 1'b0, 64'h1008, 64'hDEAD, 64'h0, 64'hDEAD);
        check("t1w_lat", got, 2);
        check("t1w_we_cnt", we_cnt, 1);
        check("t1w_we_cyc", we_cyc, 1);
        check("t1w_we_addr", we_addr, 4'd1);
        check("t1w_we_data", we_data, 64'hDEAD);
        finish("t1w");
        start(1'b0, 1'b0, 64'h100C, 64'h0, 64'h0, 64'hDEAD);
        check("t1r_lat", got, 3);
        check("t1r_we_cnt", we_cnt, 0);
        check("t1r_en_cnt", en_cnt, 1);
        finish("t1r");

        // 2: matching CAS
        start(1'b1, 1'b1, 64'h1008, 64'hBEEF, 64'hDEAD, 64'hDEAD);
        check("t2_lat", got, 3);
        check("t2_we_cnt", we_cnt, 1);
        check("t2_we_cyc", we_cyc, 2);
        check("t2_we_addr", we_addr, 4'd1);
        check("t2_we_data", we_data, 64'hBEEF);
        finish("t2");
        check("t2_fail_cnt", fail_cnt, 16'd0);
        start(1'b0, 1'b0, 64'h1008, 64'h0, 64'h0, 64'hBEEF);
        finish("t2r");

        // 3: mismatching CAS
        start(1'b1, 1'b1, 64'h1008, 64'h5, 64'h1, 64'hBEEF);
        check("t3_lat", got, 3);
        check("t3_we_cnt", we_cnt, 0);
        finish("t3");
        check("t3_fail_cnt", fail_cnt, 16'd1);
        start(1'b0, 1'b0, 64'h1008, 64'h0, 64'h0, 64'hBEEF);
        finish("t3r");

        // 4: response backpressure
        rsp_rdy = 1'b0;
        start(1'b0, 1'b0, 64'h1008, 64'h0, 64'h0, 64'hBEEF);
        check("t4_lat", got, 3);
        for (int i = 0; i < 5; i++) begin
            check("t4_val_held", rsp_val, 1'b1);
            check("t4_data_stable", rsp_data, 64'hBEEF);
            check("t4_req_rdy", req_rdy, 1'b0);
            check("t4_sram_en", sram_en, 1'b0);
            step();
        end
        rsp_rdy = 1'b1;
        finish("t4");

        // 5: out-of-range below base and past the end
        start(1'b0, 1'b0, 64'h0FF8, 64'h0, 64'h0, '1);
        check("t5r_lat", got, 2);
        check("t5r_en_cnt", en_cnt, 0);
        finish("t5r");
        start(1'b1, 1'b0, 64'h1080, 64'h1234, 64'h0, '1);
        check("t5w_lat", got, 2);
        check("t5w_en_cnt", en_cnt, 0);
        finish("t5w");
        start(1'b0, 1'b0, 64'h1000, 64'h0, 64'h0, 64'h0);
        finish("t5_mem0");

        // 6: reset while a matching CAS sits in WAIT
        req_val = 1'b1; is_write = 1'b1; is_cas = 1'b1; addr = 64'h1008; wdata = 64'h77; cas_exp = 64'hBEEF;
        step();
        req_val = 1'b0;
        check("t6_access_en", sram_en, 1'b1);
        step();
        check("t6_wait_we", sram_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", sram_we, 1'b0);
        check("t6_rst_en", sram_en, 1'b0);
        check("t6_rst_addr", sram_addr, 4'd0);
        check("t6_rst_wdata", sram_wdata, 64'h0);
        check("t6_rst_rsp_val", rsp_val, 1'b0);
        check("t6_rst_rsp_data", rsp_data, 64'h0);
        check("t6_rst_req_rdy", req_rdy, 1'b1);
        check("t6_rst_fail_cnt", fail_cnt, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6_no_rsp", rsp_val, 1'b0);
            check("t6_no_en", sram_en, 1'b0);
            step();
        end
        start(1'b0, 1'b0, 64'h1008, 64'h0, 64'h0, 64'hBEEF);
        finish("t6r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
